// File: rtl/open_cl_full_permutation_pipeline.sv
// Three-stage streaming evaluator for the Dedekind core.
// A "top" word installs a new reference truth table T and reports how many bots it
// preceded and the cycle count since the previous top. Every other word is a "bot"
// checked against the T snapshot taken at its acceptance. The check runs under all
// six permutations of x4..x6.
module open_cl_full_permutation_pipeline (
    input  logic        clock,
    input  logic        rst,
    input  logic        ivalid,
    output logic        oready,
    input  logic        startNewTop,
    input  logic [63:0] botLower,
    input  logic [63:0] botUpper,
    output logic        ovalid,
    input  logic        iready,
    output logic [63:0] summedDataPcoeffCountOut
);

    // Remap the variable index of every truth-table bit. Position i of the result
    // takes bit j of b, where j[3:0] = i[3:0] and j[4+k] = i[4+s(k)]. The argument p
    // selects one of the six permutations s of {0,1,2}.
    function automatic logic [127:0] permute(input logic [127:0] b, input logic [2:0] p);
        logic [127:0] r;
        logic [6:0]   i7;
        logic [6:0]   j;
        logic [1:0]   s0, s1, s2;
        case (p)
            3'd0:    {s0, s1, s2} = {2'd0, 2'd1, 2'd2};
            3'd1:    {s0, s1, s2} = {2'd0, 2'd2, 2'd1};
            3'd2:    {s0, s1, s2} = {2'd1, 2'd0, 2'd2};
            3'd3:    {s0, s1, s2} = {2'd1, 2'd2, 2'd0};
            3'd4:    {s0, s1, s2} = {2'd2, 2'd0, 2'd1};
            3'd5:    {s0, s1, s2} = {2'd2, 2'd1, 2'd0};
            default: {s0, s1, s2} = {2'd0, 2'd1, 2'd2};
        endcase
        r = '0;
        for (int i = 0; i < 128; i++) begin
            i7       = 7'(i);
            j[3:0]   = i7[3:0];
            j[4]     = i7[3'd4 + {1'b0, s0}];
            j[5]     = i7[3'd4 + {1'b0, s1}];
            j[6]     = i7[3'd4 + {1'b0, s2}];
            r[i]     = b[j];
        end
        return r;
    endfunction

    function automatic logic [7:0] popcount128(input logic [127:0] v);
        logic [7:0] c;
        c = '0;
        for (int i = 0; i < 128; i++) begin
            c = c + {7'd0, v[i]};
        end
        return c;
    endfunction

    logic         advance;
    logic         accept;
    logic [127:0] in_word;

    logic [127:0] top_q;
    logic [31:0]  bot_cnt_q;
    logic [31:0]  cyc_cnt_q;

    logic         s1_valid_q;
    logic         s1_is_top_q;
    logic [127:0] s1_word_q;
    logic [127:0] s1_top_q;
    logic [63:0]  s1_top_res_q;

    logic [5:0]       perm_ok;
    logic [5:0][7:0]  perm_pc;

    logic             s2_valid_q;
    logic             s2_is_top_q;
    logic [63:0]      s2_top_res_q;
    logic [5:0]       s2_ok_q;
    logic [5:0][7:0]  s2_pc_q;

    logic [2:0]   acc_cnt;
    logic [9:0]   acc_sum;

    logic         s3_valid_q;
    logic [63:0]  s3_data_q;

    // The whole pipeline moves in lockstep; a full output stage blocks everything.
    assign advance = !s3_valid_q || iready;
    assign accept  = ivalid && advance;
    assign oready  = advance;
    assign ovalid  = s3_valid_q;
    assign summedDataPcoeffCountOut = s3_data_q;
    assign in_word = {botUpper, botLower};

    // Top register, bots-since-top counter and free-running cycle counter.
    always_ff @(posedge clock) begin
        if (rst) begin
            top_q     <= '0;
            bot_cnt_q <= '0;
            cyc_cnt_q <= '0;
        end else begin
            cyc_cnt_q <= cyc_cnt_q + 32'd1;
            if (accept) begin
                if (startNewTop) begin
                    top_q     <= in_word;
                    bot_cnt_q <= '0;
                    cyc_cnt_q <= 32'd1;
                end else begin
                    bot_cnt_q <= bot_cnt_q + 32'd1;
                end
            end
        end
    end

    // Stage 1: capture the word with its own T snapshot and the would-be top result.
    always_ff @(posedge clock) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
        end else if (advance) begin
            s1_valid_q   <= ivalid;
            s1_is_top_q  <= startNewTop;
            s1_word_q    <= in_word;
            s1_top_q     <= top_q;
            s1_top_res_q <= {bot_cnt_q, cyc_cnt_q};
        end
    end

    // Subset test and popcount of T & ~P for each of the six permutations.
    always_comb begin
        logic [127:0] p;
        perm_ok = '0;
        perm_pc = '0;
        for (int k = 0; k < 6; k++) begin
            p          = permute(s1_word_q, 3'(k));
            perm_ok[k] = ~|(p & ~s1_top_q);
            perm_pc[k] = popcount128(s1_top_q & ~p);
        end
    end

    // Stage 2: register the per-permutation results.
    always_ff @(posedge clock) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
        end else if (advance) begin
            s2_valid_q   <= s1_valid_q;
            s2_is_top_q  <= s1_is_top_q;
            s2_top_res_q <= s1_top_res_q;
            s2_ok_q      <= perm_ok;
            s2_pc_q      <= perm_pc;
        end
    end

    // Count valid permutations and sum their popcounts.
    always_comb begin
        acc_cnt = '0;
        acc_sum = '0;
        for (int k = 0; k < 6; k++) begin
            if (s2_ok_q[k]) begin
                acc_cnt = acc_cnt + 3'd1;
                acc_sum = acc_sum + {2'd0, s2_pc_q[k]};
            end
        end
    end

    // Stage 3: output register; held while downstream stalls.
    always_ff @(posedge clock) begin
        if (rst) begin
            s3_valid_q <= 1'b0;
            s3_data_q  <= '0;
        end else if (advance) begin
            s3_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                if (s2_is_top_q) begin
                    s3_data_q <= s2_top_res_q;
                end else begin
                    // Bit 63 is the ECC status slot; no ECC here, so it stays 0.
                    s3_data_q <= {3'b000, {10'd0, acc_cnt}, {38'd0, acc_sum}};
                end
            end
        end
    end

endmodule

// File: tb/tb_open_cl_full_permutation_pipeline.sv
// Directed bench: a table of top/bot pairs plus hand-built sequences for counters,
// latency, backpressure and mid-stream reset. Results go through an in-order scoreboard.
module tb_open_cl_full_permutation_pipeline;

    logic        clock = 1'b0;
    logic        rst;
    logic        ivalid;
    logic        oready;
    logic        startNewTop;
    logic [63:0] botLower;
    logic [63:0] botUpper;
    logic        ovalid;
    logic        iready;
    logic [63:0] res;

    open_cl_full_permutation_pipeline dut (
        .clock                    (clock),
        .rst                      (rst),
        .ivalid                   (ivalid),
        .oready                   (oready),
        .startNewTop              (startNewTop),
        .botLower                 (botLower),
        .botUpper                 (botUpper),
        .ovalid                   (ovalid),
        .iready                   (iready),
        .summedDataPcoeffCountOut (res)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    logic [63:0] exp_q[$];
    int          acc_q[$];
    bit          lat_chk = 1'b0;
    logic [31:0] m_bots;
    logic [31:0] m_last;

    typedef struct {
        logic [127:0] top;
        logic [127:0] bot;
        int           cnt;
        int           sum;
    } vec_t;
    vec_t tbl[7];

    function automatic logic [63:0] mk(input int cnt, input int sum);
        return {3'b000, 13'(cnt), 48'(sum)};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    // Scoreboard: every delivered result must match the oldest expectation.
    always @(negedge clock) begin
        if (!rst && ovalid && iready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL extra_output: got %h, required no output", res);
            end else begin
                int a;
                check("result", res, exp_q.pop_front());
                a = acc_q.pop_front();
                // Acceptance cycle = cycle in which ivalid && oready held.
                if (lat_chk) check("latency", 64'(cyc - a), 64'd3);
            end
        end
    end

    task automatic do_reset();
        rst    = 1'b1;
        ivalid = 1'b0;
        @(posedge clock);
        #1;
        rst = 1'b0;
        exp_q.delete();
        acc_q.delete();
        m_bots = '0;
        m_last = 32'(cyc) + 32'd1;
    endtask

    // Present one word, wait for acceptance, and record what it must produce.
    task automatic send(input logic top, input logic [127:0] w, input logic [63:0] bot_exp);
        bit ok;
        ok          = 1'b0;
        ivalid      = 1'b1;
        startNewTop = top;
        {botUpper, botLower} = w;
        for (int n = 0; n < 100; n++) begin
            @(negedge clock);
            if (oready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_bad++;
            $display("FAIL send_timeout: got oready=0 for 100 cycles, required 1");
            ivalid = 1'b0;
            return;
        end
        @(posedge clock);
        #1;
        acc_q.push_back(cyc - 1);
        if (top) begin
            exp_q.push_back({m_bots, 32'(cyc) - m_last});
            m_bots = '0;
            m_last = 32'(cyc);
        end else begin
            exp_q.push_back(bot_exp);
            m_bots = m_bots + 32'd1;
        end
        ivalid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 60 && exp_q.size() != 0; n++) begin
            @(posedge clock);
            #1;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d results pending, required 0", exp_q.size());
        end
    endtask

    localparam logic [127:0] Ones = '1;

    initial begin
        tbl[0] = '{Ones, 128'h0, 6, 768};
        tbl[1] = '{Ones, 128'h1, 6, 762};
        tbl[2] = '{128'h1FFFF, 128'h10000, 2, 32};
        tbl[3] = '{128'h0, 128'h0, 6, 0};
        tbl[4] = '{128'h0, 128'h1, 0, 0};
        tbl[5] = '{128'h0000_0000_0000_0001_0000_0001_0001_0000, 128'h1_0000, 6, 12};
        tbl[6] = '{128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF,
                   128'h0000_0000_0000_0001_0000_0000_0000_0000, 4, 252};

        ivalid      = 1'b0;
        startNewTop = 1'b0;
        botLower    = '0;
        botUpper    = '0;
        iready      = 1'b1;
        do_reset();
        check("reset_ovalid", 64'(ovalid), 64'd0);
        check("reset_out", res, 64'd0);
        check("reset_oready", 64'(oready), 64'd1);

        // Table: each pair from a fresh reset, top result is {0 bots, C=0}.
        for (int i = 0; i < 7; i++) begin
            do_reset();
            send(1'b1, tbl[i].top, 64'd0);
            send(1'b0, tbl[i].bot, mk(tbl[i].cnt, tbl[i].sum));
            drain();
        end

        // Counters and latency: 5 bots, 2 idle cycles, second top gives {5, 8}.
        do_reset();
        lat_chk = 1'b1;
        send(1'b1, Ones, 64'd0);
        send(1'b0, 128'h0, mk(6, 768));
        send(1'b0, 128'h1, mk(6, 762));
        send(1'b0, Ones, mk(6, 0));
        send(1'b0, 128'h0, mk(6, 768));
        send(1'b0, 128'h1, mk(6, 762));
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        send(1'b1, 128'h0, 64'd0);
        check("second_top_expect", exp_q[exp_q.size() - 1], {32'd5, 32'd8});
        send(1'b0, 128'h0, mk(6, 0));
        drain();
        lat_chk = 1'b0;

        // Continuous stream with a 10-cycle downstream stall.
        do_reset();
        fork
            begin
                send(1'b1, Ones, 64'd0);
                send(1'b0, 128'h0, mk(6, 768));
                send(1'b0, 128'h1, mk(6, 762));
                send(1'b0, Ones, mk(6, 0));
                send(1'b1, 128'h1FFFF, 64'd0);
                send(1'b0, 128'h10000, mk(2, 32));
                send(1'b0, 128'h0, mk(6, 102));
                send(1'b0, 128'h1, mk(6, 96));
            end
            begin
                repeat (4) begin
                    @(posedge clock);
                    #1;
                end
                iready = 1'b0;
                for (int k = 0; k < 10; k++) begin
                    @(negedge clock);
                    check("stall_ovalid", 64'(ovalid), 64'd1);
                    check("stall_oready", 64'(oready), 64'd0);
                    if (exp_q.size() != 0) check("stall_hold", res, exp_q[0]);
                end
                @(posedge clock);
                #1;
                iready = 1'b1;
            end
        join
        drain();

        // Reset while results are stalled in flight: all of them must vanish.
        do_reset();
        send(1'b1, Ones, 64'd0);
        drain();
        iready = 1'b0;
        send(1'b0, 128'h0, mk(6, 768));
        send(1'b0, 128'h1, mk(6, 762));
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        check("held_out", res, mk(6, 768));
        check("held_ovalid", 64'(ovalid), 64'd1);
        check("held_oready", 64'(oready), 64'd0);
        do_reset();
        check("midreset_ovalid", 64'(ovalid), 64'd0);
        check("midreset_out", res, 64'd0);
        check("midreset_oready", 64'(oready), 64'd1);
        iready = 1'b1;
        // T was cleared by reset, so this bot sees T = 0.
        send(1'b0, 128'h0, mk(6, 0));
        send(1'b1, Ones, 64'd0);
        send(1'b0, 128'h0, mk(6, 768));
        drain();
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        check("idle_ovalid", 64'(ovalid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
